// File: rtl/imm_ext_pkg.sv
// -----------------------------------------------------------------------------
// imm_ext_pkg
// Shared constants for the registered immediate generator (imm_ext_stage).
//   EXT_OP_W      : width of the one-hot extension opcode.
//   EXT_CTRL_*    : one-hot ext_op encodings, one bit per immediate format.
//   XLEN_DEFAULT  : default datapath width.
// Optional feature macro used by imm_decode: IMM_EXT_ZICSR_EN.
// -----------------------------------------------------------------------------
package imm_ext_pkg;

  localparam int EXT_OP_W     = 7;
  localparam int XLEN_DEFAULT = 32;

  localparam logic [EXT_OP_W-1:0] EXT_CTRL_JTYPE       = 7'b000_0001;
  localparam logic [EXT_OP_W-1:0] EXT_CTRL_UTYPE       = 7'b000_0010;
  localparam logic [EXT_OP_W-1:0] EXT_CTRL_BTYPE       = 7'b000_0100;
  localparam logic [EXT_OP_W-1:0] EXT_CTRL_STYPE       = 7'b000_1000;
  localparam logic [EXT_OP_W-1:0] EXT_CTRL_ITYPE       = 7'b001_0000;
  localparam logic [EXT_OP_W-1:0] EXT_CTRL_ITYPE_SHAMT = 7'b010_0000;
  localparam logic [EXT_OP_W-1:0] EXT_CTRL_ZIMM        = 7'b100_0000;

endpackage : imm_ext_pkg

// File: rtl/imm_decode.sv
// -----------------------------------------------------------------------------
// imm_decode
// Purely combinational immediate extractor for RV32/RV64 instruction formats.
// Parameters:
//   XLEN   : output width, 32 or 64.
// Ports:
//   instr  : in,  32-bit instruction word.
//   ext_op : in,  one-hot format select (see EXT_CTRL_* in imm_ext_pkg).
//   imm    : out, XLEN-wide extended immediate (0 when err is set).
//   err    : out, ext_op not one-hot, or it selects a disabled format.
// Configuration:
//   IMM_EXT_ZICSR_EN defined   -> ZIMM yields zero-extended instr[19:15].
//   IMM_EXT_ZICSR_EN undefined -> ZIMM is treated as an illegal opcode.
// -----------------------------------------------------------------------------
module imm_decode
  import imm_ext_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]         instr,
  input  logic [EXT_OP_W-1:0] ext_op,
  output logic [XLEN-1:0]     imm,
  output logic                err
);

  // Raw immediate fields, reassembled in their architectural bit order.
  logic [11:0] i_field;
  logic [11:0] s_field;
  logic [12:0] b_field;
  logic [31:0] u_field;
  logic [20:0] j_field;

  assign i_field = instr[31:20];
  assign s_field = {instr[31:25], instr[11:7]};
  assign b_field = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_field = {instr[31:12], 12'b0};
  assign j_field = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // A size cast of a signed operand sign-extends to XLEN, which keeps the
  // formulas identical for both datapath widths.
  always_comb begin
    // NOTE: every output gets a default before the case so that no path leaves
    // it unassigned; a missing default here would infer a latch.
    imm = '0;
    err = 1'b0;
    // Only exact one-hot codes match an item; anything else (including zero or
    // multiple bits) falls to the default and is flagged.
    case (ext_op)
      EXT_CTRL_ITYPE: imm = XLEN'($signed(i_field));
      EXT_CTRL_STYPE: imm = XLEN'($signed(s_field));
      EXT_CTRL_BTYPE: imm = XLEN'($signed(b_field));
      EXT_CTRL_UTYPE: imm = XLEN'($signed(u_field));
      EXT_CTRL_JTYPE: imm = XLEN'($signed(j_field));
      EXT_CTRL_ITYPE_SHAMT: begin
        // RV64 shifts use a 6-bit shamt; RV32 only 5 bits.
        if (XLEN == 64) imm = XLEN'(instr[25:20]);
        else            imm = XLEN'(instr[24:20]);
      end
`ifdef IMM_EXT_ZICSR_EN
      EXT_CTRL_ZIMM:  imm = XLEN'(instr[19:15]);
`endif
      default: begin
        imm = '0;
        err = 1'b1;
      end
    endcase
  end

endmodule : imm_decode

// File: rtl/imm_ext_stage.sv
// -----------------------------------------------------------------------------
// imm_ext_stage
// Registered immediate generator for the decode/execute boundary. Decodes the
// immediate combinationally (imm_decode) and holds results in a main output
// register backed by a one-entry skid register, giving a 2-deep FIFO with a
// valid/ready handshake on both sides and a synchronous flush.
// Parameters:
//   XLEN  : datapath width, 32 or 64.
//   TAG_W : width of the sideband tag carried with each entry.
// Ports:
//   clk, rst  : clock (rising edge), asynchronous active-high reset.
//   flush     : synchronous flush; drops both entries and any same-cycle accept.
//   in_valid  : upstream presents instr/ext_op/in_tag.
//   in_ready  : stage can accept (skid register empty).
//   instr     : 32-bit instruction word.
//   ext_op    : one-hot immediate format select.
//   in_tag    : sideband tag.
//   out_valid : immout/out_tag/imm_err are valid.
//   out_ready : downstream accepts the current output.
//   immout    : generated immediate.
//   out_tag   : tag belonging to immout.
//   imm_err   : ext_op was illegal for this entry.
// Configuration: IMM_EXT_ZICSR_EN enables the ZIMM format (see imm_decode).
// -----------------------------------------------------------------------------
module imm_ext_stage
  import imm_ext_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instr,
  input  logic [EXT_OP_W-1:0] ext_op,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     immout,
  output logic [TAG_W-1:0]    out_tag,
  output logic                imm_err
);

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] dec_imm;
  logic            dec_err;

  imm_decode #(
    .XLEN (XLEN)
  ) u_imm_decode (
    .instr  (instr),
    .ext_op (ext_op),
    .imm    (dec_imm),
    .err    (dec_err)
  );

  // ---------------------------------------------------------------------------
  // Storage: main (output) register and skid register
  // ---------------------------------------------------------------------------
  logic             main_valid_q, main_valid_d;
  logic [XLEN-1:0]  main_imm_q,   main_imm_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic             main_err_q,   main_err_d;

  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
  logic             skid_err_q,   skid_err_d;

  logic accept;
  logic out_xfer;

  // Ready depends only on state, never on out_ready, so there is no
  // combinational path from downstream back to upstream.
  assign in_ready  = !skid_valid_q;
  assign accept    = in_valid && in_ready;
  assign out_valid = main_valid_q;
  assign out_xfer  = main_valid_q && out_ready;

  assign immout  = main_imm_q;
  assign out_tag = main_tag_q;
  assign imm_err = main_err_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_tag_d   = main_tag_q;
    main_err_d   = main_err_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_err_d   = skid_err_q;

    if (flush) begin
      // Flush outranks accept and transfer; data contents are left as-is.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_xfer) begin
      // Main is free this cycle. The older skid entry goes first to keep FIFO
      // order; an accept cannot coincide with it because in_ready is low while
      // skid is occupied.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_imm_d   = skid_imm_q;
        main_tag_d   = skid_tag_q;
        main_err_d   = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_imm_d   = dec_imm;
        main_tag_d   = in_tag;
        main_err_d   = dec_err;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Main is stalled: park the new entry in skid, which drops in_ready.
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_tag_d   = in_tag;
      skid_err_d   = dec_err;
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of statement order.
  // NOTE: the data registers are reset as well so immout/out_tag/imm_err read
  // as zero out of reset; the skid data follows the same rule for uniformity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_tag_q   <= '0;
      main_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_err_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_tag_q   <= main_tag_d;
      main_err_q   <= main_err_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_err_q   <= skid_err_d;
    end
  end

endmodule : imm_ext_stage

// File: tb/tb_imm_ext_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_ext_stage
// Directed bench for imm_ext_stage: a table of single-transaction vectors on an
// XLEN=32 instance, a few XLEN=64 vectors on a second instance, and hand-
// written sequences for back-pressure, flush and mid-stream reset.
// -----------------------------------------------------------------------------
module tb_imm_ext_stage;
  import imm_ext_pkg::*;

  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // XLEN=32 instance signals
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         instr;
  logic [EXT_OP_W-1:0] ext_op;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         immout;
  logic [TAG_W-1:0]    out_tag;
  logic                imm_err;

  // XLEN=64 instance signals
  logic                w_flush;
  logic                w_in_valid;
  logic                w_in_ready;
  logic [31:0]         w_instr;
  logic [EXT_OP_W-1:0] w_ext_op;
  logic [TAG_W-1:0]    w_in_tag;
  logic                w_out_valid;
  logic                w_out_ready;
  logic [63:0]         w_immout;
  logic [TAG_W-1:0]    w_out_tag;
  logic                w_imm_err;

  imm_ext_stage #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .ext_op    (ext_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .immout    (immout),
    .out_tag   (out_tag),
    .imm_err   (imm_err)
  );

  imm_ext_stage #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk       (clk),
    .rst       (rst),
    .flush     (w_flush),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .instr     (w_instr),
    .ext_op    (w_ext_op),
    .in_tag    (w_in_tag),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .immout    (w_immout),
    .out_tag   (w_out_tag),
    .imm_err   (w_imm_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Samples one time unit after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [EXT_OP_W-1:0] op;
    logic [31:0]         ins;
    logic [63:0]         exp_imm;
    logic                exp_err;
  } vec_t;

`ifdef IMM_EXT_ZICSR_EN
  localparam logic [63:0] ZIMM_IMM = 64'h1F;
  localparam logic        ZIMM_ERR = 1'b0;
`else
  localparam logic [63:0] ZIMM_IMM = 64'h0;
  localparam logic        ZIMM_ERR = 1'b1;
`endif

  vec_t v32[12];
  vec_t v64[3];

  initial begin
    v32[0]  = '{EXT_CTRL_ITYPE,       32'hFFF00093, 64'hFFFF_FFFF, 1'b0};
    v32[1]  = '{EXT_CTRL_ITYPE,       32'h7FF00093, 64'h0000_07FF, 1'b0};
    v32[2]  = '{EXT_CTRL_STYPE,       32'hFE112E23, 64'hFFFF_FFFC, 1'b0};
    v32[3]  = '{EXT_CTRL_UTYPE,       32'h123450B7, 64'h1234_5000, 1'b0};
    v32[4]  = '{EXT_CTRL_BTYPE,       32'hFE000EE3, 64'hFFFF_FFFC, 1'b0};
    v32[5]  = '{EXT_CTRL_BTYPE,       32'h00208463, 64'h0000_0008, 1'b0};
    v32[6]  = '{EXT_CTRL_JTYPE,       32'h0080006F, 64'h0000_0008, 1'b0};
    v32[7]  = '{EXT_CTRL_JTYPE,       32'hFFDFF0EF, 64'hFFFF_FFFC, 1'b0};
    v32[8]  = '{EXT_CTRL_ITYPE_SHAMT, 32'h03F00013, 64'h0000_001F, 1'b0};
    v32[9]  = '{7'b0000011,           32'hFFF00093, 64'h0,         1'b1};
    v32[10] = '{7'b0000000,           32'hFFF00093, 64'h0,         1'b1};
    v32[11] = '{EXT_CTRL_ZIMM,        32'h000F8000, ZIMM_IMM,      ZIMM_ERR};

    v64[0]  = '{EXT_CTRL_UTYPE,       32'h800000B7, 64'hFFFF_FFFF_8000_0000, 1'b0};
    v64[1]  = '{EXT_CTRL_ITYPE_SHAMT, 32'h03F00013, 64'h0000_0000_0000_003F, 1'b0};
    v64[2]  = '{EXT_CTRL_ITYPE,       32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

    flush = 1'b0; in_valid = 1'b0; instr = '0; ext_op = EXT_CTRL_ITYPE;
    in_tag = '0; out_ready = 1'b1;
    w_flush = 1'b0; w_in_valid = 1'b0; w_instr = '0; w_ext_op = EXT_CTRL_ITYPE;
    w_in_tag = '0; w_out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_immout",    64'(immout),    64'd0);
    check("rst_out_tag",   64'(out_tag),   64'd0);
    check("rst_imm_err",   64'(imm_err),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // XLEN=32 table, back-to-back with out_ready=1: one-cycle latency each
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      instr    = v32[i].ins;
      ext_op   = v32[i].op;
      in_tag   = TAG_W'(i + 1);
      tick();
      check($sformatf("v32[%0d]_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("v32[%0d]_imm",   i), 64'(immout),    v32[i].exp_imm);
      check($sformatf("v32[%0d]_err",   i), 64'(imm_err),   64'(v32[i].exp_err));
      check($sformatf("v32[%0d]_tag",   i), 64'(out_tag),   64'(i + 1));
    end
    in_valid = 1'b0;
    tick();
    check("drain_out_valid", 64'(out_valid), 64'd0);

    // XLEN=64 table
    for (int i = 0; i < 3; i++) begin
      w_in_valid = 1'b1;
      w_instr    = v64[i].ins;
      w_ext_op   = v64[i].op;
      w_in_tag   = TAG_W'(i + 20);
      tick();
      check($sformatf("v64[%0d]_valid", i), 64'(w_out_valid), 64'd1);
      check($sformatf("v64[%0d]_imm",   i), w_immout,         v64[i].exp_imm);
      check($sformatf("v64[%0d]_err",   i), 64'(w_imm_err),   64'(v64[i].exp_err));
      check($sformatf("v64[%0d]_tag",   i), 64'(w_out_tag),   64'(i + 20));
    end
    w_in_valid = 1'b0;

    // Back-pressure: tags 1,2 fill main and skid; a third offer is ignored
    ext_op = EXT_CTRL_ITYPE; instr = 32'h00100093;
    out_ready = 1'b0;
    in_valid = 1'b1; in_tag = 5'd1;
    tick();
    check("bp_valid_1",    64'(out_valid), 64'd1);
    check("bp_ready_1",    64'(in_ready),  64'd1);
    in_tag = 5'd2;
    tick();
    check("bp_ready_full", 64'(in_ready),  64'd0);
    check("bp_tag_head",   64'(out_tag),   64'd1);
    in_tag = 5'd3;
    tick();
    check("bp_ready_held", 64'(in_ready),  64'd0);
    check("bp_tag_held",   64'(out_tag),   64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_tag_second", 64'(out_tag),   64'd2);
    check("bp_valid_2",    64'(out_valid), 64'd1);
    check("bp_ready_back", 64'(in_ready),  64'd1);
    tick();
    check("bp_empty",      64'(out_valid), 64'd0);

    // Flush with both entries held and a simultaneous offer
    out_ready = 1'b0;
    in_valid = 1'b1; in_tag = 5'd4;
    tick();
    in_tag = 5'd5;
    tick();
    check("fl_full", 64'(in_ready), 64'd0);
    flush = 1'b1; in_tag = 5'd6;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("fl_quiet_%0d", c), 64'(out_valid), 64'd0);
    end

    // Asynchronous reset while main and skid both hold entries
    out_ready = 1'b0;
    ext_op = EXT_CTRL_ITYPE; instr = 32'hFFF00093;
    in_valid = 1'b1; in_tag = 5'd7;
    tick();
    in_tag = 5'd8;
    tick();
    in_valid = 1'b0;
    check("rs_pre_valid", 64'(out_valid), 64'd1);
    check("rs_pre_ready", 64'(in_ready),  64'd0);
    #2 rst = 1'b1;
    #1;
    check("rs_out_valid", 64'(out_valid), 64'd0);
    check("rs_immout",    64'(immout),    64'd0);
    check("rs_out_tag",   64'(out_tag),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check("rs_in_ready",  64'(in_ready),  64'd1);
    check("rs_idle",      64'(out_valid), 64'd0);
    in_valid = 1'b1; in_tag = 5'd9;
    tick();
    in_valid = 1'b0;
    check("rs_resume_valid", 64'(out_valid), 64'd1);
    check("rs_resume_imm",   64'(immout),    64'hFFFF_FFFF);
    check("rs_resume_tag",   64'(out_tag),   64'd9);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_imm_ext_stage
